// File: rtl/regfile_param_if.sv
// Register-file bus: read/write selects, write data, scoreboard controls and read-back.
// The master drives the requests; the slave (the register file) drives the results.
interface regfile_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);
  localparam int unsigned NREGS = 2 ** AW;

  logic [AW-1:0]    regr0s;
  logic [AW-1:0]    regr1s;
  logic [AW-1:0]    regws;
  logic [WIDTH-1:0] regw;
  logic             we;
  logic             incr_pc;
  logic             rsv_en;
  logic [AW-1:0]    rsv_sel;
  logic [WIDTH-1:0] regr0;
  logic [WIDTH-1:0] regr1;
  logic [WIDTH-1:0] pc;
  logic             hazard0;
  logic             hazard1;
  logic [NREGS-1:0] busy;

  modport master (
    output regr0s, regr1s, regws, regw, we, incr_pc, rsv_en, rsv_sel,
    input  regr0, regr1, pc, hazard0, hazard1, busy
  );

  modport slave (
    input  regr0s, regr1s, regws, regw, we, incr_pc, rsv_en, rsv_sel,
    output regr0, regr1, pc, hazard0, hazard1, busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parameterised register file: R0 hard-wired to zero, top register is an auto-incrementing PC,
// optional write-to-read forwarding and a per-register reservation scoreboard. State moves on negedge.
module regfile_param #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned AW      = 3,
  parameter int unsigned PC_STEP = 2,
  parameter int unsigned BYPASS  = 1
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave bus
);
  localparam int unsigned NREGS  = 2 ** AW;
  localparam int unsigned PC_IDX = NREGS - 1;
  localparam bit          BYP    = (BYPASS != 0);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic             w_wr_valid;
  logic             w_rsv_valid;
  logic [NREGS-1:0] w_busy_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_rd0;
  logic [WIDTH-1:0] w_rd1;
  logic             w_haz0;
  logic             w_haz1;

  assign w_wr_valid  = bus.we && (bus.regws != '0);
  assign w_rsv_valid = bus.rsv_en && (bus.rsv_sel != '0);
  assign w_pc_inc    = r_regs[PC_IDX] + WIDTH'(PC_STEP);

  // Reservation sets win over a same-edge write clear to the same register
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.we) w_busy_nxt[bus.regws] = 1'b0;
    if (w_rsv_valid) w_busy_nxt[bus.rsv_sel] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int unsigned i = 1; i < PC_IDX; i++) begin
        if (w_wr_valid && (bus.regws == AW'(i))) r_regs[i] <= bus.regw;
      end
      // An explicit PC write overrides the increment
      if (w_wr_valid && (bus.regws == AW'(PC_IDX))) r_regs[PC_IDX] <= bus.regw;
      else if (bus.incr_pc)                           r_regs[PC_IDX] <= w_pc_inc;
      r_busy <= w_busy_nxt;
    end
  end

  // Forwarding covers the write port only; the PC increment is never visible early
  always_comb begin
    w_rd0 = (bus.regr0s == '0) ? '0 : r_regs[bus.regr0s];
    w_rd1 = (bus.regr1s == '0) ? '0 : r_regs[bus.regr1s];
    if (BYP && w_wr_valid && (bus.regws == bus.regr0s)) w_rd0 = bus.regw;
    if (BYP && w_wr_valid && (bus.regws == bus.regr1s)) w_rd1 = bus.regw;
  end

  // A pending write clears the hazard unless the same edge re-reserves that register
  always_comb begin
    w_haz0 = r_busy[bus.regr0s];
    w_haz1 = r_busy[bus.regr1s];
    if (BYP && bus.we && !(w_rsv_valid && (bus.rsv_sel == bus.regws))) begin
      if (bus.regws == bus.regr0s) w_haz0 = 1'b0;
      if (bus.regws == bus.regr1s) w_haz1 = 1'b0;
    end
  end

  assign bus.regr0   = w_rd0;
  assign bus.regr1   = w_rd1;
  assign bus.pc      = r_regs[PC_IDX];
  assign bus.hazard0 = w_haz0;
  assign bus.hazard1 = w_haz1;
  assign bus.busy    = r_busy;
endmodule
